// File: rtl/instr_seq_pkg.sv
// Shared types for the SNACKS control sequencer: opcodes, FSM states and
// instruction classes.
package instr_seq_pkg;

  typedef enum logic [3:0] {
    OP_CLR, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_SL,  OP_SR,  OP_SET,
    OP_INC, OP_DEC, OP_ADC, OP_BZ,  OP_BNZ, OP_JMP, OP_LD,  OP_ST
  } op_code;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_ERR
  } seq_state_t;

  typedef enum logic [2:0] {
    IC_ALU, IC_BRZ, IC_BRNZ, IC_JUMP, IC_LOAD, IC_STORE
  } instr_class_t;

endpackage

// File: rtl/instr_seq_class_dec.sv
// Combinational instruction classifier: {inst_type, inst_op} -> instr_class_t.
// Set-immediate instructions (inst_type=0) always behave as ALU writes.
module instr_class_dec
  import instr_seq_pkg::*;
(
  input  logic       inst_type,
  input  logic [3:0] inst_op,
  output logic [2:0] cls
);

  instr_class_t c;

  always_comb begin
    c = IC_ALU;
    if (inst_type) begin
      case (op_code'(inst_op))
        OP_BZ:   c = IC_BRZ;
        OP_BNZ:  c = IC_BRNZ;
        OP_JMP:  c = IC_JUMP;
        OP_LD:   c = IC_LOAD;
        OP_ST:   c = IC_STORE;
        default: c = IC_ALU;
      endcase
    end
  end

  assign cls = c;

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the SNACKS core.
// Optional perf counters (cyc_cnt, ret_cnt) are enabled by INSTR_SEQ_PERF_EN.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pc_last,
  input  logic        inst_type,
  input  logic [3:0]  inst_op,
  input  logic        zero,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        pc_jump,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ret_cnt
`endif
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT - 1);

  seq_state_t      state;
  logic            lat_type;
  logic [3:0]      lat_op;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      cls_raw;
  instr_class_t    cls;

  instr_class_dec u_dec (
    .inst_type (lat_type),
    .inst_op   (lat_op),
    .cls       (cls_raw)
  );

  assign cls = instr_class_t'(cls_raw);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lat_type <= 1'b0;
      lat_op   <= 4'd0;
      to_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_FETCH;
        S_FETCH:  state <= pc_last ? S_DONE : S_DECODE;
        S_DECODE: begin
          lat_type <= inst_type;
          lat_op   <= inst_op;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (cls == IC_LOAD || cls == IC_STORE) begin
            to_cnt <= '0;
            state  <= S_MEM;
          end else begin
            state  <= S_FETCH;
          end
        end
        S_MEM: begin
          // An ack in the last allowed cycle takes priority over the timeout.
          if (dmem_ack)              state  <= (cls == IC_STORE) ? S_FETCH : S_WB;
          else if (to_cnt == TO_MAX) state  <= S_ERR;
          else                       to_cnt <= to_cnt + 1'b1;
        end
        S_WB:     state <= S_FETCH;
        S_DONE:   if (start) state <= S_FETCH;
        S_ERR:    state <= S_ERR;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_FETCH: begin
        busy    = 1'b1;
        ir_load = !pc_last;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        case (cls)
          IC_ALU:   begin reg_we = 1'b1; pc_inc = 1'b1; end
          IC_BRZ:   begin pc_branch = zero;  pc_inc = !zero; end
          IC_BRNZ:  begin pc_branch = !zero; pc_inc = zero;  end
          IC_JUMP:  pc_jump = 1'b1;
          default:  ;
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (cls == IC_STORE);
        pc_inc   = (cls == IC_STORE) && dmem_ack;
      end
      S_WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        pc_inc     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

`ifdef INSTR_SEQ_PERF_EN
  logic run_clr;
  assign run_clr = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n || run_clr) begin
      cyc_cnt <= 16'd0;
      ret_cnt <= 16'd0;
    end else begin
      if (busy && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
      if ((pc_inc || pc_branch || pc_jump) && ret_cnt != 16'hFFFF)
        ret_cnt <= ret_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: each step drives one cycle of inputs, queues
// the expected output vector, and compares it mid-cycle on the falling edge.
module tb_instr_seq;
  import instr_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start, pc_last, inst_type, zero, dmem_ack;
  logic [3:0] inst_op;
  logic ir_load, pc_inc, pc_branch, pc_jump, reg_we, mem_to_reg;
  logic dmem_req, dmem_we, busy, done, err;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  instr_seq #(.MEM_TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_last(pc_last),
    .inst_type(inst_type), .inst_op(inst_op), .zero(zero), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .busy(busy), .done(done), .err(err)
`ifdef INSTR_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Output vector bit positions
  localparam logic [10:0] IR = 11'h400, PI = 11'h200, PB = 11'h100, PJ = 11'h080,
                          WE = 11'h040, MR = 11'h020, RQ = 11'h010, DW = 11'h008,
                          BY = 11'h004, DN = 11'h002, ER = 11'h001, NONE = 11'h000;

  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic step(input logic r, input logic s, input logic pl, input logic ty,
                      input logic [3:0] op, input logic z, input logic a,
                      input logic [10:0] e, input string tag);
    logic [10:0] obs, ex;
    string t;
    rst_n = r; start = s; pc_last = pl; inst_type = ty; inst_op = op;
    zero = z; dmem_ack = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {ir_load, pc_inc, pc_branch, pc_jump, reg_we, mem_to_reg,
           dmem_req, dmem_we, busy, done, err};
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    vectors++;
    assert (obs === ex) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", t, obs, ex);
    end
    @(posedge clk); #1;
  endtask

  // Normal-run cycle: reset released, no pc_last, zero/ack low unless given.
  task automatic cyc(input logic ty, input logic [3:0] op, input logic z,
                     input logic a, input logic [10:0] e, input string tag);
    step(1'b1, 1'b0, 1'b0, ty, op, z, a, e, tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pc_last = 1'b0; inst_type = 1'b0;
    inst_op = 4'd0; zero = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, NONE, "reset_idle");
    // ack outside MEM is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, NONE, "idle_hold");
    step(1'b1, 1'b1, 1'b0, 1'b1, OP_ADD, 1'b0, 1'b1, NONE, "idle_start");

    // Two ADDs
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, IR | BY,      "add1_fetch");
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, BY,           "add1_decode");
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, WE | PI | BY, "add1_exec");
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, IR | BY,      "add2_fetch");
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, BY,           "add2_decode");
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, WE | PI | BY, "add2_exec");
`ifdef INSTR_SEQ_PERF_EN
    vectors++;
    assert (cyc_cnt === 16'd6 && ret_cnt === 16'd2) else begin
      miscompares++;
      $error("FAIL perf_cnt observed=%0d/%0d expected=6/2", cyc_cnt, ret_cnt);
    end
`endif

    // Branches and jump
    cyc(1'b1, OP_BZ,  1'b0, 1'b0, IR | BY, "bz1_fetch");
    cyc(1'b1, OP_BZ,  1'b0, 1'b0, BY,      "bz1_decode");
    cyc(1'b1, OP_BZ,  1'b1, 1'b0, PB | BY, "bz_taken");
    cyc(1'b1, OP_BZ,  1'b0, 1'b0, IR | BY, "bz2_fetch");
    cyc(1'b1, OP_BZ,  1'b0, 1'b0, BY,      "bz2_decode");
    cyc(1'b1, OP_BZ,  1'b0, 1'b0, PI | BY, "bz_not_taken");
    cyc(1'b1, OP_BNZ, 1'b0, 1'b0, IR | BY, "bnz_fetch");
    cyc(1'b1, OP_BNZ, 1'b0, 1'b0, BY,      "bnz_decode");
    cyc(1'b1, OP_BNZ, 1'b0, 1'b0, PB | BY, "bnz_taken");
    cyc(1'b1, OP_JMP, 1'b0, 1'b0, IR | BY, "jmp_fetch");
    cyc(1'b1, OP_JMP, 1'b0, 1'b0, BY,      "jmp_decode");
    cyc(1'b1, OP_JMP, 1'b1, 1'b0, PJ | BY, "jmp_exec");

    // Set-immediate ignores the op field, even one that looks like LD
    cyc(1'b0, OP_LD, 1'b0, 1'b0, IR | BY,      "seti_fetch");
    cyc(1'b0, OP_LD, 1'b0, 1'b0, BY,           "seti_decode");
    cyc(1'b0, OP_LD, 1'b0, 1'b0, WE | PI | BY, "seti_exec");

    // LD with 3 wait cycles
    cyc(1'b1, OP_LD, 1'b0, 1'b0, IR | BY, "ld_fetch");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "ld_decode");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "ld_exec");
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_LD, 1'b0, 1'b0, RQ | BY, "ld_wait");
    cyc(1'b1, OP_LD, 1'b0, 1'b1, RQ | BY,           "ld_ack");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, WE | MR | PI | BY, "ld_wb");

    // ST with one wait cycle
    cyc(1'b1, OP_ST, 1'b0, 1'b0, IR | BY,           "st_fetch");
    cyc(1'b1, OP_ST, 1'b0, 1'b0, BY,                "st_decode");
    cyc(1'b1, OP_ST, 1'b0, 1'b0, BY,                "st_exec");
    cyc(1'b1, OP_ST, 1'b0, 1'b0, RQ | DW | BY,      "st_wait");
    cyc(1'b1, OP_ST, 1'b0, 1'b1, RQ | DW | PI | BY, "st_ack");

    // LD acked on the 8th MEM cycle: no timeout
    cyc(1'b1, OP_LD, 1'b0, 1'b0, IR | BY, "ld8_fetch");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "ld8_decode");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "ld8_exec");
    for (int i = 0; i < 7; i++) cyc(1'b1, OP_LD, 1'b0, 1'b0, RQ | BY, "ld8_wait");
    cyc(1'b1, OP_LD, 1'b0, 1'b1, RQ | BY,           "ld8_ack_last");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, WE | MR | PI | BY, "ld8_wb");

    // Program end, then resume
    step(1'b1, 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, BY,      "last_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, OP_ADD, 1'b0, 1'b1, DN,      "done_hold");
    step(1'b1, 1'b1, 1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, DN,      "done_start");
    step(1'b1, 1'b0, 1'b0, 1'b1, OP_ST,  1'b0, 1'b0, IR | BY, "resume_fetch");

    // ST with no ack: timeout into sticky ERR
    cyc(1'b1, OP_ST, 1'b0, 1'b0, BY, "to_decode");
    cyc(1'b1, OP_ST, 1'b0, 1'b0, BY, "to_exec");
    for (int i = 0; i < 8; i++) cyc(1'b1, OP_ST, 1'b0, 1'b0, RQ | DW | BY, "to_wait");
    cyc(1'b1, OP_ST, 1'b0, 1'b0, ER, "err_set");
    step(1'b1, 1'b1, 1'b0, 1'b1, OP_ST, 1'b0, 1'b1, ER, "err_sticky");
    step(1'b0, 1'b0, 1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ER, "err_rst_edge");
    step(1'b1, 1'b0, 1'b0, 1'b1, OP_LD, 1'b0, 1'b0, NONE, "err_cleared");

    // Reset held 2 cycles while in MEM
    step(1'b1, 1'b1, 1'b0, 1'b1, OP_LD, 1'b0, 1'b0, NONE, "rm_start");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, IR | BY, "rm_fetch");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "rm_decode");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, BY,      "rm_exec");
    step(1'b0, 1'b0, 1'b0, 1'b1, OP_LD, 1'b0, 1'b0, RQ | BY, "rm_mem_rst");
    step(1'b0, 1'b0, 1'b0, 1'b1, OP_LD, 1'b0, 1'b1, NONE,    "rm_rst2");
    step(1'b1, 1'b1, 1'b0, 1'b1, OP_LD, 1'b0, 1'b0, NONE,    "rm_after_rst");
    cyc(1'b1, OP_LD, 1'b0, 1'b0, IR | BY, "rm_refetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
